// File: rtl/ac_out_collector.sv
// ac_out_collector
// Receiving end of the arithmetic core's result stream. Packs signed DATA_W
// results (in_data/in_en) into LANES-wide words for one frame, buffers them in
// a small first-word-fall-through FIFO and writes them to feature-map memory at
// consecutive word addresses over a valid/ready port. The core cannot be
// stalled, so a word pushed into a full FIFO is dropped and flagged.
//
// State table:
//   IDLE    | waiting for start; in_en ignored
//   COLLECT | capturing results, pushing packed words
//   DRAIN   | final word pushed (or dropped), waiting for FIFO to empty
//   DONE    | one-cycle done pulse
//
// Ports:
//   clk, reset (async, active-low)
//   start, base_addr, frame_len     frame setup, sampled when start accepted
//   in_data, in_en                  result stream from the core
//   wr_valid, wr_ready, wr_addr,
//   wr_data, wr_last                memory write port
//   busy, done, overflow, count     status
module ac_out_collector #(
    parameter int DATA_W     = 8,
    parameter int LANES      = 4,
    parameter int FIFO_DEPTH = 8,
    parameter int ADDR_W     = 10
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic [ADDR_W-1:0]         base_addr,
    input  logic [15:0]               frame_len,
    input  logic [DATA_W-1:0]         in_data,
    input  logic                      in_en,
    output logic                      wr_valid,
    input  logic                      wr_ready,
    output logic [ADDR_W-1:0]         wr_addr,
    output logic [DATA_W*LANES-1:0]   wr_data,
    output logic                      wr_last,
    output logic                      busy,
    output logic                      done,
    output logic                      overflow,
    output logic [15:0]               count
);

    localparam int WORD_W = DATA_W * LANES;
    localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int LANE_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [LANE_W-1:0] LAST_LANE = LANE_W'(LANES - 1);
    localparam logic [PTR_W:0]    FILL_MAX  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]    FILL_ONE  = (PTR_W + 1)'(1);

    typedef enum logic [1:0] {IDLE, COLLECT, DRAIN, DONE} state_t;

    state_t state, state_nxt;

    logic [15:0]       frame_len_q;
    logic [LANE_W-1:0] lane_idx;
    logic [DATA_W-1:0] pack [LANES];
    logic [WORD_W-1:0] push_word;

    logic [WORD_W-1:0] mem_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] mem_last;
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [PTR_W:0]    fill;

    logic start_ok, cap, is_final, push, pop, fifo_empty, fifo_full, fifo_wr, drop;

    assign start_ok   = (state == IDLE) && start;
    assign cap        = (state == COLLECT) && in_en;
    assign is_final   = cap && ((count + 16'd1) == frame_len_q);
    assign push       = cap && ((lane_idx == LAST_LANE) || is_final);
    assign fifo_empty = (fill == '0);
    assign fifo_full  = (fill == FILL_MAX);
    assign pop        = !fifo_empty && wr_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign fifo_wr    = push && (!fifo_full || pop);
    assign drop       = push && fifo_full && !pop;

    // Current result goes into lane_idx; lower lanes come from the pack
    // register, upper lanes stay zero for a short final word.
    always_comb begin
        push_word = '0;
        for (int i = 0; i < LANES; i++) begin
            if (i < int'(lane_idx))
                push_word[i*DATA_W +: DATA_W] = pack[i];
            else if (i == int'(lane_idx))
                push_word[i*DATA_W +: DATA_W] = in_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = (frame_len == 16'd0) ? DONE : COLLECT;
            COLLECT: if (is_final) state_nxt = DRAIN;
            // Also leaves when the last resident word is popped this cycle,
            // so done follows the final beat by one cycle.
            DRAIN:   if (fifo_empty || (fill == FILL_ONE && pop)) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign busy = (state == COLLECT) || (state == DRAIN);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_len_q <= '0;
            lane_idx    <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            wr_addr     <= '0;
            for (int i = 0; i < LANES; i++) pack[i] <= '0;
        end else if (start_ok) begin
            frame_len_q <= frame_len;
            lane_idx    <= '0;
            count       <= '0;
            overflow    <= 1'b0;
            wr_addr     <= base_addr;
            for (int i = 0; i < LANES; i++) pack[i] <= '0;
        end else begin
            if (cap) begin
                count <= count + 16'd1;
                if (push) begin
                    lane_idx <= '0;
                    for (int i = 0; i < LANES; i++) pack[i] <= '0;
                end else begin
                    pack[lane_idx] <= in_data;
                    lane_idx       <= lane_idx + 1'b1;
                end
            end
            if (drop) overflow <= 1'b1;
            if (pop)  wr_addr  <= wr_addr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            mem_data[wr_ptr] <= push_word;
            mem_last[wr_ptr] <= is_final;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            fill   <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({fifo_wr, pop})
                2'b10:   fill <= fill + 1'b1;
                2'b01:   fill <= fill - 1'b1;
                default: fill <= fill;
            endcase
        end
    end

    // Memory contents are not reset; gate the head so an empty FIFO shows zeros.
    assign wr_valid = !fifo_empty;
    assign wr_data  = fifo_empty ? '0 : mem_data[rd_ptr];
    assign wr_last  = fifo_empty ? 1'b0 : mem_last[rd_ptr];

endmodule

// File: tb/tb_ac_out_collector.sv
module tb_ac_out_collector;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [9:0]  base_addr;
    logic [15:0] frame_len;
    logic [7:0]  in_data;
    logic        in_en;
    logic        wr_valid;
    logic        wr_ready;
    logic [9:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_last;
    logic        busy;
    logic        done;
    logic        overflow;
    logic [15:0] count;

    ac_out_collector #(.DATA_W(8), .LANES(4), .FIFO_DEPTH(8), .ADDR_W(10)) dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .frame_len(frame_len), .in_data(in_data), .in_en(in_en),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
        .wr_data(wr_data), .wr_last(wr_last), .busy(busy), .done(done),
        .overflow(overflow), .count(count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [15:0]      frame_len;
        logic [9:0]       base;
        logic [63:0]      data;
        int               gap;
        int               nb;
        logic [1:0][31:0] exp_d;
        logic [1:0][9:0]  exp_a;
    } vec_t;

    vec_t vecs [4];

    int checks   = 0;
    int failures = 0;

    logic [31:0] bq_d [$];
    logic [9:0]  bq_a [$];
    logic        bq_l [$];
    int          bq_c [$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    logic        prev_stall = 1'b0;
    logic [31:0] pd;
    logic [9:0]  pa;
    logic        pl;

    function automatic vec_t mk(input logic [15:0] fl, input logic [9:0] b,
                                input logic [63:0] d, input int g, input int n,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [9:0] a0, input logic [9:0] a1);
        vec_t v;
        v.frame_len = fl; v.base = b; v.data = d; v.gap = g; v.nb = n;
        v.exp_d[0] = d0; v.exp_d[1] = d1;
        v.exp_a[0] = a0; v.exp_a[1] = a1;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Records accepted beats and done pulses; checks the write port holds while stalled.
    task automatic monitor();
        forever begin
            @(negedge clk);
            if (reset) begin
                if (prev_stall) begin
                    chk("stall_valid", 64'(wr_valid), 64'd1);
                    chk("stall_data", 64'(wr_data), 64'(pd));
                    chk("stall_addr", 64'(wr_addr), 64'(pa));
                    chk("stall_last", 64'(wr_last), 64'(pl));
                end
                if (wr_valid && wr_ready) begin
                    bq_d.push_back(wr_data);
                    bq_a.push_back(wr_addr);
                    bq_l.push_back(wr_last);
                    bq_c.push_back(cyc);
                end
                if (done) begin
                    done_cnt++;
                    done_cyc = cyc;
                end
                prev_stall = wr_valid && !wr_ready;
                pd = wr_data; pa = wr_addr; pl = wr_last;
            end else begin
                prev_stall = 1'b0;
            end
        end
    endtask

    task automatic do_start(input logic [15:0] len, input logic [9:0] base);
        @(posedge clk); #1;
        start = 1'b1; frame_len = len; base_addr = base;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic feed_byte(input logic [7:0] d, input int gap);
        in_en = 1'b1; in_data = d;
        @(posedge clk); #1;
        in_en = 1'b0;
        repeat (gap - 1) begin @(posedge clk); #1; end
    endtask

    task automatic wait_done(input int dc0);
        for (int k = 0; k < 300; k++) begin
            if (done_cnt > dc0) break;
            @(posedge clk); #1;
        end
        chk("done_timeout", 64'(done_cnt > dc0), 64'd1);
        @(posedge clk); #1;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int b0, dc0, nbeats;
        logic [63:0] dv;
        wr_ready = 1'b1;
        b0  = bq_d.size();
        dc0 = done_cnt;
        dv  = v.data;
        do_start(v.frame_len, v.base);
        for (int i = 0; i < int'(v.frame_len); i++) feed_byte(dv[i*8 +: 8], v.gap);
        wait_done(dc0);
        nbeats = bq_d.size() - b0;
        chk({nm, "_nbeats"}, 64'(nbeats), 64'(v.nb));
        for (int j = 0; j < v.nb && j < nbeats; j++) begin
            chk({nm, "_data"}, 64'(bq_d[b0+j]), 64'(v.exp_d[j]));
            chk({nm, "_addr"}, 64'(bq_a[b0+j]), 64'(v.exp_a[j]));
            chk({nm, "_last"}, 64'(bq_l[b0+j]), 64'(j == v.nb - 1));
        end
        if (nbeats > 0)
            chk({nm, "_done_gap"}, 64'(done_cyc - bq_c[b0+nbeats-1]), 64'd1);
        chk({nm, "_count"}, 64'(count), 64'(v.frame_len));
        chk({nm, "_overflow"}, 64'(overflow), 64'd0);
        chk({nm, "_busy_idle"}, 64'(busy), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        chk({nm, "_done_once"}, 64'(done_cnt - dc0), 64'd1);
    endtask

    initial begin
        int b0, dc0, sc;
        logic [31:0] ew;

        vecs[0] = mk(16'd8, 10'h010, 64'h0807060504030201, 8, 2,
                     32'h04030201, 32'h08070605, 10'h010, 10'h011);
        vecs[1] = mk(16'd6, 10'h020, 64'h0000060504030201, 1, 2,
                     32'h04030201, 32'h00000605, 10'h020, 10'h021);
        vecs[2] = mk(16'd4, 10'h005, 64'h00000000007F80FF, 2, 1,
                     32'h007F80FF, 32'h0, 10'h005, 10'h0);
        vecs[3] = mk(16'd8, 10'h3FF, 64'h1817161514131211, 1, 2,
                     32'h14131211, 32'h18171615, 10'h3FF, 10'h000);

        reset = 1'b0; start = 1'b0; base_addr = '0; frame_len = '0;
        in_data = '0; in_en = 1'b0; wr_ready = 1'b1;
        fork monitor(); join_none

        repeat (3) @(posedge clk);
        #1;
        chk("rst_wr_valid", 64'(wr_valid), 64'd0);
        chk("rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("rst_wr_data", 64'(wr_data), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        reset = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i], $sformatf("vec%0d", i));

        // Zero-length frame: done quickly, no beats.
        b0 = bq_d.size(); dc0 = done_cnt; sc = cyc;
        do_start(16'd0, 10'h123);
        wait_done(dc0);
        chk("zero_nbeats", 64'(bq_d.size() - b0), 64'd0);
        chk("zero_done_lat", 64'((done_cyc - sc) <= 2), 64'd1);

        // Stalled memory, 40 back-to-back results: 8 words kept, 2 dropped.
        wr_ready = 1'b0;
        b0 = bq_d.size(); dc0 = done_cnt;
        do_start(16'd40, 10'h100);
        for (int i = 0; i < 40; i++) begin
            if (i == 32) begin
                chk("ovf_full_flag", 64'(overflow), 64'd0);
                chk("ovf_full_valid", 64'(wr_valid), 64'd1);
                chk("ovf_full_head", 64'(wr_data), 64'h04030201);
            end
            if (i == 36) chk("ovf_after9", 64'(overflow), 64'd1);
            feed_byte(8'(i + 1), 1);
        end
        chk("ovf_count", 64'(count), 64'd40);
        chk("ovf_busy", 64'(busy), 64'd1);
        chk("ovf_head_kept", 64'(wr_data), 64'h04030201);
        wr_ready = 1'b1;
        wait_done(dc0);
        chk("ovf_nbeats", 64'(bq_d.size() - b0), 64'd8);
        for (int k = 0; k < 8 && (b0 + k) < bq_d.size(); k++) begin
            ew = {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
            chk("ovf_data", 64'(bq_d[b0+k]), 64'(ew));
            chk("ovf_addr", 64'(bq_a[b0+k]), 64'(10'h100 + 10'(k)));
            chk("ovf_last", 64'(bq_l[b0+k]), 64'd0);
        end
        chk("ovf_sticky", 64'(overflow), 64'd1);

        // wr_ready toggling every cycle during 16 results.
        b0 = bq_d.size(); dc0 = done_cnt;
        do_start(16'd16, 10'h200);
        fork
            begin
                for (int i = 0; i < 16; i++) feed_byte(8'(i + 1), 1);
            end
            begin
                for (int k = 0; k < 400 && done_cnt == dc0; k++) begin
                    wr_ready = ~wr_ready;
                    @(posedge clk); #1;
                end
            end
        join
        wr_ready = 1'b1;
        wait_done(dc0);
        chk("tog_nbeats", 64'(bq_d.size() - b0), 64'd4);
        for (int k = 0; k < 4 && (b0 + k) < bq_d.size(); k++) begin
            ew = {8'(4*k+4), 8'(4*k+3), 8'(4*k+2), 8'(4*k+1)};
            chk("tog_data", 64'(bq_d[b0+k]), 64'(ew));
            chk("tog_addr", 64'(bq_a[b0+k]), 64'(10'h200 + 10'(k)));
            chk("tog_last", 64'(bq_l[b0+k]), 64'(k == 3));
        end
        chk("tog_overflow", 64'(overflow), 64'd0);

        // Reset mid-frame after 5 results, with a word waiting at the port.
        wr_ready = 1'b0;
        do_start(16'd16, 10'h050);
        for (int i = 0; i < 5; i++) feed_byte(8'(i + 1), 1);
        chk("pre_rst_valid", 64'(wr_valid), 64'd1);
        chk("pre_rst_count", 64'(count), 64'd5);
        #2;
        reset = 1'b0;
        #1;
        chk("mid_rst_wr_valid", 64'(wr_valid), 64'd0);
        chk("mid_rst_wr_addr", 64'(wr_addr), 64'd0);
        chk("mid_rst_wr_data", 64'(wr_data), 64'd0);
        chk("mid_rst_wr_last", 64'(wr_last), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_done", 64'(done), 64'd0);
        chk("mid_rst_overflow", 64'(overflow), 64'd0);
        chk("mid_rst_count", 64'(count), 64'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        run_vec(vecs[1], "post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ac_out_collector.md
Name: ac_out_collector

Overview:
- Receiving end of the arithmetic core's result stream: consumes the core's signed 8-bit `out` / `out_en` pulses for one frame (one output feature map row set) and packs them into 32-bit words.
- Buffers packed words in a small FIFO and writes them to feature-map memory over a valid/ready write interface at consecutive addresses.
- The core cannot be stalled, so the block absorbs bursty results and flags any loss.

Parameters:
- DATA_W, 8, width of one result from the arithmetic core (signed)
- LANES, 4, results packed per memory word; word width = DATA_W*LANES
- FIFO_DEPTH, 8, packed-word FIFO entries; must be a power of 2
- ADDR_W, 10, memory word-address width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a frame and samples base_addr and frame_len
- base_addr  in  ADDR_W  word address of the first write of the frame
- frame_len  in  16  number of results expected in the frame
- in_data  in  DATA_W  result byte; connects to core `out`
- in_en  in  1  result valid strobe; connects to core `out_en`
- wr_valid  out  1  write beat valid
- wr_ready  in  1  memory accepts the beat when wr_valid && wr_ready at a rising edge
- wr_addr  out  ADDR_W  word address of the current beat
- wr_data  out  DATA_W*LANES  packed word; lane 0 = bits [7:0] = earliest result
- wr_last  out  1  high on the final beat of the frame
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse after the final beat is accepted
- overflow  out  1  sticky; a packed word was dropped because the FIFO was full
- count  out  16  results captured so far in the current frame

Behaviour:
- Reset (reset=0, async): state IDLE.
  - All outputs 0: wr_valid, wr_addr, wr_data, wr_last, busy, done, overflow, count.
  - FIFO emptied; lane index cleared; pack register cleared.
- FSM states: IDLE, COLLECT, DRAIN, DONE.
  - IDLE: start with frame_len!=0 -> COLLECT. start with frame_len==0 -> DONE (no writes). in_en is ignored.
  - COLLECT: every in_en cycle stores in_data into lane[lane_idx] and increments count.
    - Push when lane_idx==LANES-1, or when this result makes count==frame_len.
    - Pushed word = {in_data, pack lanes below lane_idx}; unfilled upper lanes are zero.
    - The final word of the frame is tagged last. After the final push -> DRAIN.
  - DRAIN: wait for FIFO empty with the last beat accepted -> DONE.
  - DONE: done=1 and busy=0 for exactly one cycle -> IDLE.
- start is ignored outside IDLE.
- Accepting start clears overflow and count, zeroes lane_idx, and loads wr_addr=base_addr.
- FIFO and write port:
  - First-word-fall-through: a word pushed at edge N drives wr_data/wr_last with wr_valid=1 during cycle N+1.
  - Each accepted beat pops the FIFO and increments wr_addr by 1; wraps modulo 2^ADDR_W.
  - wr_valid, wr_data, wr_addr and wr_last hold stable while wr_valid && !wr_ready.
  - Push and pop in the same cycle are allowed, including when full (the pop frees the slot).
- Overflow:
  - A push while full with no pop in that cycle drops the word and sets overflow=1 (sticky until next start).
  - count still advances. If the dropped word was tagged last, the FSM goes straight to DONE once the FIFO empties.
- in_data arriving on consecutive cycles (in_en every cycle) must be captured without loss.
- busy=1 in COLLECT and DRAIN.

Test Plan:
- Eight results 0x01..0x08 on in_en every 8 cycles, frame_len=8, base_addr=0x010, wr_ready=1 -> beats 0x04030201 @0x010 and 0x08070605 @0x011 with wr_last=1; done pulses one cycle after the second beat; count=8; overflow=0.
- frame_len=6, results 0x01..0x06 -> second beat 0x00000605 @base+1 with wr_last=1; no third beat.
- Signed values -1,-128,127,0, frame_len=4 -> single beat 0x007F80FF with wr_last=1.
- wr_ready=0 throughout, 40 back-to-back results, frame_len=40 -> 8 words buffered, overflow=1 after the 9th push. Then wr_ready=1 -> exactly 8 beats with unchanged data, then done.
- wr_ready toggling 1/0 each cycle during 16 results -> 4 beats at consecutive addresses, data and address stable while stalled.
- start with frame_len=0 -> done two cycles later, no wr_valid. Separately, assert reset=0 mid-frame after 5 results -> all outputs 0 immediately; a new start behaves as a fresh frame.
